// File: rtl/audio_gain_ramp.sv
// ---------------------------------------------------------------------------
// audio_gain_ramp
//
// Gain stage between the audio sample buffer and the AC97 sample input.
// Takes one signed sample at a time, multiplies it by an unsigned fixed-point
// gain (unity = 2**(GAIN_W-1)), floors and saturates the result, and presents
// it downstream. The applied gain moves one LSB toward the requested gain
// every RAMP_DIV consumed samples, so volume changes and mute do not click.
//
// Ports:
//   clk          system clock
//   reset_b      asynchronous active-low reset
//   in_valid     upstream sample available (level)
//   in_data      upstream sample, two's complement
//   in_ack       one-cycle pulse: in_data has been captured
//   out_valid    scaled sample available (level, held until out_ack)
//   out_data     scaled, saturated sample
//   out_ack      downstream has taken out_data
//   gain_target  requested gain
//   mute         forces the effective target gain to zero
//   gain_cur     gain currently applied
//   clip         one-cycle pulse, coincident with out_valid rising, when the
//                presented sample was saturated
// ---------------------------------------------------------------------------
module audio_gain_ramp #(
  parameter int DATA_W    = 18,
  parameter int GAIN_W    = 8,
  parameter int GAIN_INIT = 128,
  parameter int RAMP_DIV  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic              mute,
  output logic [GAIN_W-1:0] gain_cur,
  output logic              clip
);

  // Gain is fixed point with one integer bit: 128 == 1.0 for GAIN_W = 8.
  localparam int FRAC_W = GAIN_W - 1;
  // Signed sample times a zero-extended gain needs DATA_W + GAIN_W + 1 bits.
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   sample_reg;
  logic [GAIN_W-1:0]   gain_reg;
  logic [CNT_W-1:0]    ramp_cnt_reg;
  logic                in_ack_reg;
  logic                out_valid_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic                clip_reg;

  // -------------------------------------------------------------------------
  // Datapath: multiply, floor-shift, saturate
  // -------------------------------------------------------------------------
  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] shifted;
  logic [GAIN_W+1:0]        head;
  logic                     overflow;
  logic [DATA_W-1:0]        sat_value;

  // Both operands are brought to the full product width first, so the
  // multiply is exact: the true product always fits in PROD_W signed bits.
  assign sample_ext = {{(PROD_W-DATA_W){sample_reg[DATA_W-1]}}, sample_reg};
  assign gain_ext   = {{(PROD_W-GAIN_W){1'b0}}, gain_reg};
  assign product    = sample_ext * gain_ext;

  // Arithmetic shift floors toward negative infinity (-1 * 0.5 -> -1).
  assign shifted = product >>> FRAC_W;

  // The shifted value fits in DATA_W bits only if every bit from the output
  // sign bit upward is a copy of that sign bit.
  assign head     = shifted[PROD_W-1:DATA_W-1];
  assign overflow = ~((&head) | ~(|head));

  always_comb begin
    sat_value = shifted[DATA_W-1:0];
    if (overflow) begin
      sat_value = shifted[PROD_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // -------------------------------------------------------------------------
  // Gain ramp: one LSB toward the effective target, never past it
  // -------------------------------------------------------------------------
  logic [GAIN_W-1:0] eff_target;
  logic [GAIN_W-1:0] gain_step;
  logic              ramp_wrap;

  assign eff_target = mute ? '0 : gain_target;
  assign ramp_wrap  = (ramp_cnt_reg == CNT_W'(RAMP_DIV - 1));

  // Stepping only when strictly below/above the target keeps the gain inside
  // 0..2**GAIN_W-1 without any explicit wrap guard.
  always_comb begin
    gain_step = gain_reg;
    if (gain_reg < eff_target) begin
      gain_step = gain_reg + GAIN_W'(1);
    end else if (gain_reg > eff_target) begin
      gain_step = gain_reg - GAIN_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg     <= IDLE;
      sample_reg    <= '0;
      gain_reg      <= GAIN_W'(GAIN_INIT);
      ramp_cnt_reg  <= '0;
      in_ack_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      clip_reg      <= 1'b0;
    end else begin
      // Both pulses last exactly one cycle unless re-armed below.
      in_ack_reg <= 1'b0;
      clip_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sample_reg <= in_data;
            in_ack_reg <= 1'b1;
            state_reg  <= MULT;
          end
        end

        MULT: begin
          // gain_reg cannot change in this state, so the sample is scaled by
          // the gain in effect during this cycle.
          out_data_reg  <= sat_value;
          out_valid_reg <= 1'b1;
          clip_reg      <= overflow;
          state_reg     <= HOLD;
        end

        HOLD: begin
          // Returning to IDLE (rather than capturing here) means an in_valid
          // present at this edge is taken one edge later.
          if (out_ack) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
            if (ramp_wrap) begin
              ramp_cnt_reg <= '0;
              gain_reg     <= gain_step;
            end else begin
              ramp_cnt_reg <= ramp_cnt_reg + CNT_W'(1);
            end
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ack    = in_ack_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign gain_cur  = gain_reg;
  assign clip      = clip_reg;

endmodule

// File: tb/tb_audio_gain_ramp.sv
// ---------------------------------------------------------------------------
// tb_audio_gain_ramp
//
// Self-checking bench for audio_gain_ramp. Expected samples come from plain
// integer arithmetic (multiply, floor divide by 128, clamp to 18-bit range);
// expected gain comes from counting consumed samples and stepping toward the
// target on every RAMP_DIV-th one.
// ---------------------------------------------------------------------------
module tb_audio_gain_ramp;

  localparam int DATA_W   = 18;
  localparam int GAIN_W   = 8;
  localparam int RAMP_DIV = 4;
  localparam int N_RAND   = 1000;

  logic              clk;
  logic              reset_b;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ack;
  logic [GAIN_W-1:0] gain_target;
  logic              mute;
  logic [GAIN_W-1:0] gain_cur;
  logic              clip;

  int total    = 0;
  int bad      = 0;
  int timeouts = 0;

  // Reference model state: applied gain and samples consumed since reset.
  int m_gain = 128;
  int m_done = 0;

  audio_gain_ramp #(
    .DATA_W   (DATA_W),
    .GAIN_W   (GAIN_W),
    .GAIN_INIT(128),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ack    (out_ack),
    .gain_target(gain_target),
    .mute       (mute),
    .gain_cur   (gain_cur),
    .clip       (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int floor_scale(int s, int g);
    int p;
    int q;
    p = s * g;
    q = p / 128;
    if (p < 0 && (p % 128) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp18(int v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic logic clips(int s, int g);
    return (floor_scale(s, g) != clamp18(floor_scale(s, g)));
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(262143)) - 131072;
  endfunction

  task automatic model_consume(int tgt, logic m);
    int eff;
    m_done++;
    if (m_done % RAMP_DIV == 0) begin
      eff = m ? 0 : tgt;
      if (m_gain < eff) m_gain++;
      else if (m_gain > eff) m_gain--;
    end
  endtask

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    m_gain = 128;
    m_done = 0;
  endtask

  // One complete transaction; reports what was observed. out_ack is raised
  // one cycle after out_valid so the clip pulse width can be seen.
  task automatic run_sample(input int d, output int got, output logic got_clip,
                            output logic clip_late, output int lat_ack,
                            output int lat_out);
    logic ok;
    got = 0; got_clip = 1'b0; clip_late = 1'b0; lat_ack = 0; lat_out = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 18'(d);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat_ack++;
      if (in_ack === 1'b1) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!ok) begin timeouts++; return; end
    lat_out = lat_ack;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat_out++;
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin timeouts++; return; end
    got      = int'($signed(out_data));
    got_clip = clip;
    @(negedge clk);
    clip_late = clip;
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  task automatic ramp_to(int tgt, logic m);
    int got, la, lo, guard;
    logic gc, gl;
    gain_target = 8'(tgt);
    mute = m;
    guard = 0;
    while (m_gain != (m ? 0 : tgt) && guard < 2000) begin
      run_sample(int'($urandom_range(2000)) - 1000, got, gc, gl, la, lo);
      model_consume(tgt, m);
      guard++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int got, la, lo, to0;
    logic gc, gl;
    to0 = timeouts;
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL reset_in_ack: got %b, expected 0", in_ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    total++; if (out_data !== 18'd0) begin bad++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
    total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip: got %b, expected 0", clip); end
    total++; if (gain_cur !== 8'd128) begin bad++; $display("FAIL reset_gain: got %0d, expected 128", gain_cur); end
    reset_b = 1'b1;
    m_gain = 128; m_done = 0;

    // Move the gain off its reset value so the async reset is observable.
    gain_target = 8'd132;
    for (int i = 0; i < 4; i++) begin
      run_sample(500, got, gc, gl, la, lo);
      model_consume(132, 1'b0);
    end
    total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL pre_reset_gain: got %0d, expected %0d", gain_cur, m_gain); end

    // Park a sample in HOLD and reset between clock edges.
    @(negedge clk);
    in_valid = 1'b1; in_data = 18'd777;
    for (int i = 0; i < 20 && in_ack !== 1'b1; i++) @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_before_reset: got out_valid %b, expected 1", out_valid); end
    #3 reset_b = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid: got %b, expected 0", out_valid); end
    total++; if (gain_cur !== 8'd128) begin bad++; $display("FAIL async_reset_gain: got %0d, expected 128", gain_cur); end
    @(negedge clk);
    reset_b = 1'b1;
    m_gain = 128; m_done = 0;
    gain_target = 8'd128;

    run_sample(1000, got, gc, gl, la, lo);
    model_consume(128, 1'b0);
    total++; if (got !== 1000) begin bad++; $display("FAIL first_sample_data: got %0d, expected 1000", got); end
    total++; if (la !== 1) begin bad++; $display("FAIL in_ack_latency: got %0d, expected 1", la); end
    total++; if (lo !== 2) begin bad++; $display("FAIL out_valid_latency: got %0d, expected 2", lo); end
    total++; if (gc !== 1'b0) begin bad++; $display("FAIL first_sample_clip: got %b, expected 0", gc); end
    total++; if (timeouts !== to0) begin bad++; $display("FAIL reset_timeouts: got %0d, expected %0d", timeouts, to0); end
  endtask

  task automatic test_scaling();
    int vals[6] = '{20000, -20000, -1, 131071, -131072, 0};
    int got, la, lo, e, to0;
    logic gc, gl;
    to0 = timeouts;
    gain_target = 8'd128; mute = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_sample(vals[i], got, gc, gl, la, lo);
      e = clamp18(floor_scale(vals[i], m_gain));
      total++; if (got !== e) begin bad++; $display("FAIL unity_data[%0d]: got %0d, expected %0d", i, got, e); end
      total++; if (gc !== 1'b0) begin bad++; $display("FAIL unity_clip[%0d]: got %b, expected 0", i, gc); end
      model_consume(128, 1'b0);
      total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL unity_gain[%0d]: got %0d, expected %0d", i, gain_cur, m_gain); end
    end
    total++; if (timeouts !== to0) begin bad++; $display("FAIL scaling_timeouts: got %0d, expected %0d", timeouts, to0); end
  endtask

  task automatic test_ramp();
    int got, la, lo, d, e, to0, guard;
    logic gc, gl;
    to0 = timeouts;
    do_reset();
    gain_target = 8'd132; mute = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      d = rand_sample();
      run_sample(d, got, gc, gl, la, lo);
      e = clamp18(floor_scale(d, m_gain));
      total++; if (got !== e) begin bad++; $display("FAIL ramp_up_data[%0d]: got %0d, expected %0d", k, got, e); end
      model_consume(132, 1'b0);
      total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL ramp_up_gain[%0d]: got %0d, expected %0d", k, gain_cur, m_gain); end
    end
    total++; if (gain_cur !== 8'd132) begin bad++; $display("FAIL ramp_up_final: got %0d, expected 132", gain_cur); end

    mute = 1'b1; guard = 0;
    while (m_gain > 120 && guard < 200) begin
      d = rand_sample();
      run_sample(d, got, gc, gl, la, lo);
      e = clamp18(floor_scale(d, m_gain));
      total++; if (got !== e) begin bad++; $display("FAIL mute_data: got %0d, expected %0d", got, e); end
      model_consume(132, 1'b1);
      total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL mute_gain: got %0d, expected %0d", gain_cur, m_gain); end
      guard++;
    end
    total++; if (gain_cur !== 8'd120) begin bad++; $display("FAIL mute_reached: got %0d, expected 120", gain_cur); end

    mute = 1'b0; guard = 0;
    while (m_gain < 132 && guard < 200) begin
      d = rand_sample();
      run_sample(d, got, gc, gl, la, lo);
      e = clamp18(floor_scale(d, m_gain));
      total++; if (got !== e) begin bad++; $display("FAIL unmute_data: got %0d, expected %0d", got, e); end
      model_consume(132, 1'b0);
      total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL unmute_gain: got %0d, expected %0d", gain_cur, m_gain); end
      guard++;
    end
    total++; if (gain_cur !== 8'd132) begin bad++; $display("FAIL unmute_final: got %0d, expected 132", gain_cur); end
    total++; if (timeouts !== to0) begin bad++; $display("FAIL ramp_timeouts: got %0d, expected %0d", timeouts, to0); end
  endtask

  task automatic test_saturation();
    int vals[6] = '{100000, -100000, 131071, -131072, 500, -500};
    int got, la, lo, e, to0;
    logic gc, gl, ec;
    to0 = timeouts;
    ramp_to(255, 1'b0);
    total++; if (gain_cur !== 8'd255) begin bad++; $display("FAIL sat_gain_reached: got %0d, expected 255", gain_cur); end
    for (int i = 0; i < 6; i++) begin
      run_sample(vals[i], got, gc, gl, la, lo);
      e  = clamp18(floor_scale(vals[i], m_gain));
      ec = clips(vals[i], m_gain);
      total++; if (got !== e) begin bad++; $display("FAIL sat_data[%0d]: got %0d, expected %0d", i, got, e); end
      total++; if (gc !== ec) begin bad++; $display("FAIL sat_clip[%0d]: got %b, expected %b", i, gc, ec); end
      total++; if (gl !== 1'b0) begin bad++; $display("FAIL sat_clip_width[%0d]: got %b, expected 0", i, gl); end
      model_consume(255, 1'b0);
    end
    total++; if (timeouts !== to0) begin bad++; $display("FAIL sat_timeouts: got %0d, expected %0d", timeouts, to0); end
  endtask

  task automatic test_low_gain();
    int vals[6] = '{-1, 3, -3, 1000, -131072, 131071};
    int got, la, lo, d, e, to0;
    logic gc, gl;
    to0 = timeouts;
    ramp_to(64, 1'b0);
    total++; if (gain_cur !== 8'd64) begin bad++; $display("FAIL half_gain_reached: got %0d, expected 64", gain_cur); end
    for (int i = 0; i < 6; i++) begin
      run_sample(vals[i], got, gc, gl, la, lo);
      e = clamp18(floor_scale(vals[i], m_gain));
      total++; if (got !== e) begin bad++; $display("FAIL half_data[%0d]: got %0d, expected %0d", i, got, e); end
      model_consume(64, 1'b0);
    end
    ramp_to(64, 1'b1);
    total++; if (gain_cur !== 8'd0) begin bad++; $display("FAIL zero_gain_reached: got %0d, expected 0", gain_cur); end
    for (int i = 0; i < 8; i++) begin
      d = rand_sample();
      run_sample(d, got, gc, gl, la, lo);
      e = clamp18(floor_scale(d, m_gain));
      total++; if (got !== e) begin bad++; $display("FAIL zero_data[%0d]: got %0d, expected %0d", i, got, e); end
      total++; if (gc !== 1'b0) begin bad++; $display("FAIL zero_clip[%0d]: got %b, expected 0", i, gc); end
      model_consume(64, 1'b1);
      total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL zero_gain_hold[%0d]: got %0d, expected %0d", i, gain_cur, m_gain); end
    end
    mute = 1'b0;
    total++; if (timeouts !== to0) begin bad++; $display("FAIL low_timeouts: got %0d, expected %0d", timeouts, to0); end
  endtask

  task automatic test_backpressure();
    int d1, d2, first, g0, acks, got, e, to0;
    logic ok;
    to0 = timeouts;
    ramp_to(128, 1'b0);
    gain_target = 8'd200;   // gain must not creep while a sample is held
    d1 = int'($urandom_range(200000)) - 100000;
    d2 = int'($urandom_range(200000)) - 100000;
    @(negedge clk);
    in_valid = 1'b1; in_data = 18'(d1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ack === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) timeouts++;
    in_data = 18'(d2);      // in_valid stays high throughout
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) timeouts++;
    first = int'($signed(out_data));
    g0 = int'(gain_cur);
    e = clamp18(floor_scale(d1, m_gain));
    total++; if (first !== e) begin bad++; $display("FAIL bp_data: got %0d, expected %0d", first, e); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++; if (int'($signed(out_data)) !== e) begin bad++; $display("FAIL bp_stable[%0d]: got %0d, expected %0d", c, $signed(out_data), e); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b, expected 1", c, out_valid); end
      total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL bp_no_ack[%0d]: got %b, expected 0", c, in_ack); end
      total++; if (int'(gain_cur) !== g0) begin bad++; $display("FAIL bp_gain[%0d]: got %0d, expected %0d", c, gain_cur, g0); end
    end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    model_consume(200, 1'b0);
    acks = (in_ack === 1'b1) ? 1 : 0;
    total++; if (in_ack !== 1'b0) begin bad++; $display("FAIL bp_exit_no_capture: got %b, expected 0", in_ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_exit_valid: got %b, expected 0", out_valid); end
    @(negedge clk);
    total++; if (in_ack !== 1'b1) begin bad++; $display("FAIL bp_capture_next: got %b, expected 1", in_ack); end
    if (in_ack === 1'b1) acks++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ack === 1'b1) acks++;
    end
    total++; if (acks !== 1) begin bad++; $display("FAIL bp_single_ack: got %0d, expected 1", acks); end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid: got %b, expected 1", out_valid); end
    got = int'($signed(out_data));
    e = clamp18(floor_scale(d2, m_gain));
    total++; if (got !== e) begin bad++; $display("FAIL bp_second_data: got %0d, expected %0d", got, e); end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    model_consume(200, 1'b0);
    total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL bp_gain_after: got %0d, expected %0d", gain_cur, m_gain); end
    total++; if (timeouts !== to0) begin bad++; $display("FAIL bp_timeouts: got %0d, expected %0d", timeouts, to0); end
  endtask

  // Free-running producer and consumer with random gaps, back-to-back
  // offers, stray out_ack outside HOLD, and occasional target/mute changes.
  task automatic test_back_to_back();
    int    sent[$];
    int    recv[$];
    logic  rclip[$];
    int    rtgt[$];
    logic  rmute[$];
    logic  holding;
    int    held;
    logic  hclip;
    int    unstable, spurious, n, e;
    logic  ec;
    holding = 1'b0; held = 0; hclip = 1'b0; unstable = 0; spurious = 0;
    in_valid = 1'b0; out_ack = 1'b0;
    for (int cyc = 0; cyc < 40000 && recv.size() < N_RAND; cyc++) begin
      @(negedge clk);
      if ($urandom_range(99) == 0) gain_target = 8'($urandom_range(255));
      if ($urandom_range(299) == 0) mute = ~mute;
      if (in_ack === 1'b1 && (!in_valid || out_valid === 1'b1)) spurious++;
      // producer
      if (in_valid && in_ack === 1'b1) begin
        sent.push_back(int'($signed(in_data)));
        if (sent.size() < N_RAND && $urandom_range(1) == 1) in_data = 18'(rand_sample());
        else in_valid = 1'b0;
      end else if (!in_valid && sent.size() < N_RAND && $urandom_range(2) == 0) begin
        in_valid = 1'b1;
        in_data  = 18'(rand_sample());
      end
      // consumer
      if (out_valid === 1'b1) begin
        if (!holding) begin
          holding = 1'b1;
          held    = int'($signed(out_data));
          hclip   = clip;
        end else if (int'($signed(out_data)) != held) begin
          unstable++;
        end
        out_ack = ($urandom_range(2) == 0);
        if (out_ack) begin
          recv.push_back(held);
          rclip.push_back(hclip);
          rtgt.push_back(int'(gain_target));
          rmute.push_back(mute);
          holding = 1'b0;
        end
      end else begin
        out_ack = ($urandom_range(3) == 0);
      end
    end
    @(negedge clk);
    out_ack = 1'b0; in_valid = 1'b0;
    total++; if (recv.size() !== N_RAND) begin bad++; $display("FAIL rand_recv_count: got %0d, expected %0d", recv.size(), N_RAND); end
    total++; if (sent.size() !== N_RAND) begin bad++; $display("FAIL rand_sent_count: got %0d, expected %0d", sent.size(), N_RAND); end
    n = (recv.size() < sent.size()) ? recv.size() : sent.size();
    for (int i = 0; i < n; i++) begin
      e  = clamp18(floor_scale(sent[i], m_gain));
      ec = clips(sent[i], m_gain);
      total++; if (recv[i] !== e) begin bad++; $display("FAIL rand_data[%0d]: got %0d, expected %0d (gain %0d)", i, recv[i], e, m_gain); end
      total++; if (rclip[i] !== ec) begin bad++; $display("FAIL rand_clip[%0d]: got %b, expected %b", i, rclip[i], ec); end
      model_consume(rtgt[i], rmute[i]);
    end
    total++; if (gain_cur !== 8'(m_gain)) begin bad++; $display("FAIL rand_gain_final: got %0d, expected %0d", gain_cur, m_gain); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL rand_hold_stable: got %0d changes, expected 0", unstable); end
    total++; if (spurious !== 0) begin bad++; $display("FAIL rand_spurious_ack: got %0d, expected 0", spurious); end
  endtask

  initial begin
    reset_b     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ack     = 1'b0;
    gain_target = 8'd128;
    mute        = 1'b0;
    test_reset();
    test_scaling();
    test_ramp();
    test_saturation();
    test_low_gain();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule
